label_window_vote: RTL and testbench



---
 rtl/label_window_vote.sv | 139 +++++++++++++
 tb/tb_label_window_vote.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/label_window_vote.sv
// Sliding-window majority vote over the valence/arousal label pairs, with a one-entry output stage.
// Defining LABEL_VOTE_FLUSH_EN adds a flush input that empties the window.
module label_window_vote #(
    parameter int WINDOW = 5,
    parameter int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic clk,
    input  logic rst,
`ifdef LABEL_VOTE_FLUSH_EN
    input  logic flush,
`endif
    input  logic valence_in,
    input  logic arousal_in,
    input  logic din_valid,
    output logic din_ready,
    output logic valence_out,
    output logic arousal_out,
    output logic dout_valid,
    input  logic dout_ready,
    output logic warm
);

    // state      | meaning
    // ST_EMPTY   | fill == 0, no labels held
    // ST_FILLING | 0 < fill < WINDOW
    // ST_FULL    | fill == WINDOW, each accept evicts the oldest label
    typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_FULL} state_t;

    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(WINDOW);

    state_t            state;
    logic [CNT_W-1:0]  fill;
    logic [CNT_W-1:0]  val_ones;
    logic [CNT_W-1:0]  aro_ones;
    logic [WINDOW-1:0] val_sr;
    logic [WINDOW-1:0] aro_sr;

    logic              flush_w;
    logic              accept;
    logic              xfer;
    logic              win_full;
    logic [CNT_W-1:0]  fill_base;
    logic [CNT_W-1:0]  fill_nxt;
    logic [CNT_W-1:0]  val_ones_base;
    logic [CNT_W-1:0]  aro_ones_base;
    logic [CNT_W-1:0]  val_ones_nxt;
    logic [CNT_W-1:0]  aro_ones_nxt;
    logic [WINDOW-1:0] val_sr_base;
    logic [WINDOW-1:0] aro_sr_base;
    logic [WINDOW-1:0] val_sr_nxt;
    logic [WINDOW-1:0] aro_sr_nxt;
    logic              val_evict;
    logic              aro_evict;

`ifdef LABEL_VOTE_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign din_ready = !dout_valid || dout_ready;
    assign accept    = din_valid && din_ready;
    assign xfer      = dout_valid && dout_ready;

    // Tie goes to the newest label; only reachable with an even fill.
    function automatic logic vote(input logic [CNT_W-1:0] ones,
                                  input logic [CNT_W-1:0] n,
                                  input logic newest);
        logic [CNT_W:0] twice;
        logic [CNT_W:0] n_ext;
        twice = {ones, 1'b0};
        n_ext = {1'b0, n};
        if (twice > n_ext)
            return 1'b1;
        else if (twice < n_ext)
            return 1'b0;
        else
            return newest;
    endfunction

    // A flush in the same cycle as an accept clears first, so the new pair is the sole entry.
    always_comb begin
        fill_base     = flush_w ? '0 : fill;
        val_ones_base = flush_w ? '0 : val_ones;
        aro_ones_base = flush_w ? '0 : aro_ones;
        val_sr_base   = flush_w ? '0 : val_sr;
        aro_sr_base   = flush_w ? '0 : aro_sr;
        win_full      = !flush_w && (state == ST_FULL);

        fill_nxt  = win_full ? fill_base : fill_base + CNT_W'(1);
        val_evict = win_full && val_sr_base[WINDOW-1];
        aro_evict = win_full && aro_sr_base[WINDOW-1];

        val_ones_nxt = val_ones_base + CNT_W'(valence_in) - CNT_W'(val_evict);
        aro_ones_nxt = aro_ones_base + CNT_W'(arousal_in) - CNT_W'(aro_evict);

        val_sr_nxt = (val_sr_base << 1) | WINDOW'(valence_in);
        aro_sr_nxt = (aro_sr_base << 1) | WINDOW'(arousal_in);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_EMPTY;
            fill        <= '0;
            val_ones    <= '0;
            aro_ones    <= '0;
            val_sr      <= '0;
            aro_sr      <= '0;
            valence_out <= 1'b0;
            arousal_out <= 1'b0;
            dout_valid  <= 1'b0;
            warm        <= 1'b0;
        end else if (accept) begin
            val_sr      <= val_sr_nxt;
            aro_sr      <= aro_sr_nxt;
            fill        <= fill_nxt;
            val_ones    <= val_ones_nxt;
            aro_ones    <= aro_ones_nxt;
            state       <= (fill_nxt == FILL_MAX) ? ST_FULL : ST_FILLING;
            warm        <= (fill_nxt == FILL_MAX);
            valence_out <= vote(val_ones_nxt, fill_nxt, valence_in);
            arousal_out <= vote(aro_ones_nxt, fill_nxt, arousal_in);
            dout_valid  <= 1'b1;
        end else begin
            if (flush_w) begin
                state    <= ST_EMPTY;
                fill     <= '0;
                val_ones <= '0;
                aro_ones <= '0;
                val_sr   <= '0;
                aro_sr   <= '0;
                warm     <= 1'b0;
            end
            if (xfer)
                dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_label_window_vote.sv
// Bench for label_window_vote: vector table plus a queue-based scoreboard fed by a window model.
module tb_label_window_vote;

    localparam int WINDOW = 5;

    logic clk = 1'b0;
    logic rst;
    logic valence_in, arousal_in, din_valid, dout_ready;
    logic din_ready, valence_out, arousal_out, dout_valid, warm;
`ifdef LABEL_VOTE_FLUSH_EN
    logic flush;
`endif

    label_window_vote #(.WINDOW(WINDOW)) dut (
        .clk(clk),
        .rst(rst),
`ifdef LABEL_VOTE_FLUSH_EN
        .flush(flush),
`endif
        .valence_in(valence_in),
        .arousal_in(arousal_in),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .valence_out(valence_out),
        .arousal_out(arousal_out),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .warm(warm)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int xfer_cnt = 0;

    logic [1:0] sbq[$];
    logic       hv[$];
    logic       ha[$];
    logic       mv, mr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic qvote(input logic q[$]);
        int ones = 0;
        foreach (q[i]) ones += int'(q[i]);
        if (2 * ones > q.size()) return 1'b1;
        if (2 * ones < q.size()) return 1'b0;
        return q[q.size()-1];
    endfunction

    // Scoreboard: checks the current output against the queue, then predicts the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            sbq.delete();
            hv.delete();
            ha.delete();
        end else begin
            mv = (sbq.size() != 0);
            mr = !mv || dout_ready;
            chk("sb_dout_valid", 32'(dout_valid), 32'(mv));
            if (mv) chk("sb_voted_pair", 32'({valence_out, arousal_out}), 32'(sbq[0]));
            chk("sb_din_ready", 32'(din_ready), 32'(mr));
            chk("sb_warm", 32'(warm), 32'(hv.size() == WINDOW));
            if (mv && dout_ready) begin
                void'(sbq.pop_front());
                xfer_cnt++;
            end
`ifdef LABEL_VOTE_FLUSH_EN
            if (flush) begin
                hv.delete();
                ha.delete();
            end
`endif
            if (din_valid && mr) begin
                hv.push_back(valence_in);
                ha.push_back(arousal_in);
                if (hv.size() > WINDOW) void'(hv.pop_front());
                if (ha.size() > WINDOW) void'(ha.pop_front());
                sbq.push_back({qvote(hv), qvote(ha)});
            end
        end
    end

    typedef struct {
        logic dv, v, a, dr;
        logic ev, ea, ew;
    } vec_t;

    vec_t tbl[13];

    task automatic drive(input logic dv, input logic v, input logic a, input logic dr);
        din_valid  = dv;
        valence_in = v;
        arousal_in = a;
        dout_ready = dr;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Valence 1,1,0,0,0 then five 1s then 0,0,0; arousal the opposite.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        rst = 1'b0;
`ifdef LABEL_VOTE_FLUSH_EN
        flush = 1'b0;
`endif
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_valence_out", 32'(valence_out), 32'd0);
        chk("rst_arousal_out", 32'(arousal_out), 32'd0);
        chk("rst_warm", 32'(warm), 32'd0);
        chk("rst_din_ready", 32'(din_ready), 32'd1);
        #1 rst = 1'b1;

        // Back-to-back accepts with hand-computed votes.
        for (int i = 0; i <= 13; i++) begin
            @(posedge clk);
            #1;
            if (i < 13) drive(tbl[i].dv, tbl[i].v, tbl[i].a, tbl[i].dr);
            else drive(1'b0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("tbl%0d_dout_valid", i-1), 32'(dout_valid), 32'd1);
                chk($sformatf("tbl%0d_valence_out", i-1), 32'(valence_out), 32'(tbl[i-1].ev));
                chk($sformatf("tbl%0d_arousal_out", i-1), 32'(arousal_out), 32'(tbl[i-1].ea));
                chk($sformatf("tbl%0d_warm", i-1), 32'(warm), 32'(tbl[i-1].ew));
            end
        end

        // Output stall for 10 cycles with input pending.
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_din_ready", 32'(din_ready), 32'd0);
            chk("stall_dout_valid", 32'(dout_valid), 32'd1);
            chk("stall_warm", 32'(warm), 32'd1);
            valence_in = ~valence_in;
        end
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);

        // Reset with fill=3 and a pending output that must be dropped.
        do_reset();
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1 drive(1'b1, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1 drive(1'b1, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_dout_valid", 32'(dout_valid), 32'd0);
        chk("midrst_valence_out", 32'(valence_out), 32'd0);
        chk("midrst_arousal_out", 32'(arousal_out), 32'd0);
        chk("midrst_warm", 32'(warm), 32'd0);
        chk("midrst_din_ready", 32'(din_ready), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 drive(1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("postrst_valence_out", 32'(valence_out), 32'd1);
        chk("postrst_warm", 32'(warm), 32'd0);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("postrst_tie_newest", 32'(valence_out), 32'd0);
        repeat (2) @(posedge clk);

`ifdef LABEL_VOTE_FLUSH_EN
        // Full window of 1s, then flush together with an accept of 0.
        for (int k = 0; k < WINDOW; k++) begin
            @(posedge clk);
            #1 drive(1'b1, 1'b1, 1'b1, 1'b1);
        end
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 1'b0, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        chk("preflush_warm", 32'(warm), 32'd1);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 1'b0, 1'b1);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_valence_out", 32'(valence_out), 32'd0);
        chk("flush_warm", 32'(warm), 32'd0);
        repeat (2) @(posedge clk);
`endif

        // Full-throughput streaming of 20 pairs.
        @(posedge clk);
        xfer_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1 drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            @(negedge clk);
            if (k > 0) chk("stream_dout_valid", 32'(dout_valid), 32'd1);
        end
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("stream_transfers", 32'(xfer_cnt), 32'd20);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
